edlo_uio_arbiter: RTL and testbench



---
 rtl/edlo_uio_arbiter.sv | 141 ++++++++++++++
 tb/tb_edlo_uio_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edlo_uio_arbiter.sv
// Round-robin arbiter for the shared 8-bit uio pad bus: one requester per burst, direction fixed per grant.
// Optional macro EDLO_ARB_TURNAROUND_EN inserts one pads-released TURN cycle between consecutive grants.
module edlo_uio_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     wr,
    input  logic [8*N_REQ-1:0]   wdata,
    input  logic [7:0]           uio_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic [7:0]           rdata,
    output logic [N_REQ-1:0]     rvalid,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Handshake: req is a level held for the whole burst; gnt answers one
    // cycle later and stays high until the cycle after req drops or the
    // burst limit hands the bus to another pending requester.
    state_t          state;
    logic [IW-1:0]   owner;  // current owner in GRANT, last granted otherwise
    logic            dir;
    logic [CW-1:0]   cnt;

    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] others;
    logic             others_pend;
    logic             release_now;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    cand;
    logic [7:0]       owner_wdata;
    logic             drive;

    // Search starts just after the last granted index and wraps around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = owner;
        cand       = owner;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(owner) + i) % N_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_oh    = N_REQ'(1) << owner;
        others      = req & ~owner_oh;
        others_pend = |others;
        release_now = !req[owner] || ((cnt == CNT_LAST) && others_pend);
        owner_wdata = wdata[8*int'(owner) +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= IW'(N_REQ - 1);
            dir    <= 1'b0;
            cnt    <= '0;
            gnt    <= '0;
            rdata  <= 8'h00;
            rvalid <= '0;
        end else begin
            if (state == GRANT && !dir) begin
                rdata  <= uio_in;
                rvalid <= owner_oh;
            end else begin
                rvalid <= '0;
            end

            case (state)
                IDLE, TURN: begin
                    if (pick_found) begin
                        state <= GRANT;
                        owner <= pick_idx;
                        dir   <= wr[pick_idx];
                        cnt   <= '0;
                        gnt   <= N_REQ'(1) << pick_idx;
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        if (others_pend) begin
`ifdef EDLO_ARB_TURNAROUND_EN
                            state <= TURN;
                            gnt   <= '0;
`else
                            state <= GRANT;
                            owner <= pick_idx;
                            dir   <= wr[pick_idx];
                            cnt   <= '0;
                            gnt   <= N_REQ'(1) << pick_idx;
`endif
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else begin
                        // A lone owner may keep the bus past the limit; the counter just wraps.
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Pad drive is decoded from registered state so reset releases the pads at once.
    always_comb begin
        drive     = (state == GRANT) && dir;
        uio_oe    = drive ? 8'hFF : 8'h00;
        uio_out   = drive ? owner_wdata : 8'h00;
        busy      = (state != IDLE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_edlo_uio_arbiter.sv
// Bench for edlo_uio_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_edlo_uio_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 8;
    localparam int W    = 2*N + 25;
`ifdef EDLO_ARB_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   wr;
    logic [8*N-1:0] wdata;
    logic [7:0]     uio_in;
    logic [N-1:0]   gnt;
    logic [7:0]     uio_out;
    logic [7:0]     uio_oe;
    logic [7:0]     rdata;
    logic [N-1:0]   rvalid;
    logic           busy;
    logic [1:0]     dbg_state;

    int compared   = 0;
    int mismatched = 0;
    logic [W-1:0] exp_q[$];

    edlo_uio_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .wdata(wdata), .uio_in(uio_in),
        .gnt(gnt), .uio_out(uio_out), .uio_oe(uio_oe), .rdata(rdata),
        .rvalid(rvalid), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int           m_mode;   // 0 idle, 1 granted, 2 turnaround gap
    int           m_owner;
    int           m_last;
    int           m_cnt;
    bit           m_dir;
    logic [7:0]   m_rdata;
    logic [N-1:0] m_rvalid;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
        m_dir = 1'b0; m_rdata = 8'h00; m_rvalid = '0;
    endtask

    task automatic model_grant(input int who);
        m_mode = 1; m_owner = who; m_last = who; m_dir = wr[who]; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] oth;
        int nxt;
        if (m_mode == 1 && !m_dir) begin
            m_rdata  = uio_in;
            m_rvalid = N'(1) << m_owner;
        end else begin
            m_rvalid = '0;
        end
        if (m_mode != 1) begin
            nxt = rr_pick(req, m_last);
            if (nxt >= 0) model_grant(nxt);
            else m_mode = 0;
        end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            if (!req[m_owner] || (m_cnt == MAXB - 1 && oth != 0)) begin
                if (oth == 0) m_mode = 0;
                else if (TURN_EN) m_mode = 2;
                else model_grant(rr_pick(req, m_last));
            end else begin
                m_cnt = (m_cnt + 1) % MAXB;
            end
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [N-1:0] g;
        logic [7:0]   oe;
        logic [7:0]   o;
        g = '0; oe = 8'h00; o = 8'h00;
        if (m_mode == 1) begin
            g[m_owner] = 1'b1;
            if (m_dir) begin
                oe = 8'hFF;
                o  = wdata[8*m_owner +: 8];
            end
        end
        return {g, oe, o, m_rdata, m_rvalid, (m_mode != 0)};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {gnt, uio_oe, uio_out, rdata, rvalid, busy};
    endfunction

    // ---------------- scoreboard / driver ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] w,
                        input logic [8*N-1:0] wd, input logic [7:0] ui);
        logic [W-1:0] e;
        req = r; wr = w; wdata = wd; uio_in = ui;
        model_edge();
        exp_q.push_back(model_out());
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check("model", dut_vec(), e);
    endtask

    task automatic do_reset();
        req = '0; wr = '0; wdata = '0; uio_in = 8'h00;
        rst = 1'b1;
        model_reset();
        #1;
        check("reset", {dut_vec(), dbg_state}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] wr;
        logic [31:0]  wdata;
        logic [7:0]   uin;
        logic [N-1:0] e_gnt;
        logic [7:0]   e_oe;
        logic [7:0]   e_out;
        logic [N-1:0] e_rv;
        logic [7:0]   e_rd;
        logic         e_busy;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [N-1:0] r;
        logic [31:0]  fw;
        logic [N-1:0] eg;
        logic [7:0]   eo;
        logic [7:0]   eout;
        int           k;

        rst = 1'b1;
        req = '0; wr = '0; wdata = '0; uio_in = 8'h00;

        //            req      wr       wdata          uin    gnt      oe     out    rv       rd     busy
        tbl[0]  = '{4'b0000, 4'b0000, 32'h00000000, 8'hEE, 4'b0000, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0001, 32'hDEADBEA5, 8'hEE, 4'b0001, 8'hFF, 8'hA5, 4'b0000, 8'h00, 1'b1};
        tbl[2]  = '{4'b0001, 4'b0001, 32'h1122333C, 8'hEE, 4'b0001, 8'hFF, 8'h3C, 4'b0000, 8'h00, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0001, 32'h1122333C, 8'hEE, 4'b0000, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0000, 32'h00000000, 8'h00, 4'b0100, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b1};
        tbl[5]  = '{4'b0100, 4'b0000, 32'h00000000, 8'h10, 4'b0100, 8'h00, 8'h00, 4'b0100, 8'h10, 1'b1};
        tbl[6]  = '{4'b0100, 4'b0000, 32'h00000000, 8'h11, 4'b0100, 8'h00, 8'h00, 4'b0100, 8'h11, 1'b1};
        tbl[7]  = '{4'b0100, 4'b0000, 32'h00000000, 8'h12, 4'b0100, 8'h00, 8'h00, 4'b0100, 8'h12, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0000, 32'h00000000, 8'h13, 4'b0000, 8'h00, 8'h00, 4'b0100, 8'h13, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 32'h00000000, 8'hEE, 4'b0000, 8'h00, 8'h00, 4'b0000, 8'h13, 1'b0};
        tbl[10] = '{4'b0001, 4'b0001, 32'h00000077, 8'hEE, 4'b0001, 8'hFF, 8'h77, 4'b0000, 8'h13, 1'b1};
        tbl[11] = '{4'b0001, 4'b0000, 32'h00000077, 8'hEE, 4'b0001, 8'hFF, 8'h77, 4'b0000, 8'h13, 1'b1};
        tbl[12] = '{4'b0001, 4'b0000, 32'h00000077, 8'hEE, 4'b0001, 8'hFF, 8'h77, 4'b0000, 8'h13, 1'b1};
        tbl[13] = '{4'b0000, 4'b0000, 32'h00000077, 8'hEE, 4'b0000, 8'h00, 8'h00, 4'b0000, 8'h13, 1'b0};
        tbl[14] = '{4'b0001, 4'b0000, 32'h00000077, 8'hEE, 4'b0001, 8'h00, 8'h00, 4'b0000, 8'h13, 1'b1};
        tbl[15] = '{4'b0000, 4'b0000, 32'h00000000, 8'h9A, 4'b0000, 8'h00, 8'h00, 4'b0001, 8'h9A, 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 32'h00000000, 8'hEE, 4'b0000, 8'h00, 8'h00, 4'b0000, 8'h9A, 1'b0};

        // ---- reset state and table vectors ----
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req, tbl[i].wr, tbl[i].wdata, tbl[i].uin);
            check($sformatf("tbl[%0d]", i), dut_vec(),
                  {tbl[i].e_gnt, tbl[i].e_oe, tbl[i].e_out, tbl[i].e_rd, tbl[i].e_rv, tbl[i].e_busy});
        end

        // ---- fairness: all four requesting, 8-cycle bursts in order 0,1,2,3,0 ----
        do_reset();
        fw = 32'h44332211;
        for (int c = 1; c <= 40; c++) begin
            step(4'b1111, 4'b1111, fw, 8'h00);
            if (TURN_EN && ((c - 1) % 9 == 8)) begin
                eg = '0; eo = 8'h00; eout = 8'h00;
            end else begin
                k    = TURN_EN ? ((c - 1) / 9) % 4 : ((c - 1) / 8) % 4;
                eg   = N'(1) << k;
                eo   = 8'hFF;
                eout = fw[8*k +: 8];
            end
            check($sformatf("fair c%0d", c), {gnt, uio_oe, uio_out}, {eg, eo, eout});
        end
        step(4'b0000, 4'b0000, fw, 8'h00);

        // ---- lone requester keeps the bus through counter wrap ----
        for (int c = 0; c < 20; c++) begin
            step(4'b0010, 4'b0010, 32'h00005A00, 8'h00);
            check("lone", {gnt, busy, uio_oe, uio_out}, {4'b0010, 1'b1, 8'hFF, 8'h5A});
        end
        step(4'b0000, 4'b0000, 32'h0, 8'h00);

        // ---- simultaneous release of req[3] and raise of req[1] ----
        for (int c = 0; c < 3; c++) begin
            step(4'b1000, 4'b1000, 32'hC3000000, 8'h00);
            check("sim owner3", {gnt, uio_oe}, {4'b1000, 8'hFF});
        end
        step(4'b0010, 4'b0010, 32'h0000B400, 8'h00);
        if (TURN_EN) begin
            check("sim turn", {gnt, busy, uio_oe}, {4'b0000, 1'b1, 8'h00});
            step(4'b0010, 4'b0010, 32'h0000B400, 8'h00);
        end
        check("sim owner1", {gnt, uio_oe, uio_out}, {4'b0010, 8'hFF, 8'hB4});
        step(4'b0000, 4'b0000, 32'h0, 8'h00);

        // ---- handover where everyone drops during the gap ----
        step(4'b1000, 4'b0000, 32'h0, 8'h00);
        step(4'b0100, 4'b0000, 32'h0, 8'h00);
        step(4'b0000, 4'b0000, 32'h0, 8'h00);
        step(4'b0000, 4'b0000, 32'h0, 8'h00);
        check("drop idle", {gnt, busy}, {4'b0000, 1'b0});

        // ---- reset mid-burst releases the pads without a clock edge ----
        step(4'b0001, 4'b0001, 32'h000000A5, 8'h00);
        check("rst burst", {uio_oe, uio_out}, {8'hFF, 8'hA5});
        step(4'b0001, 4'b0001, 32'h000000A5, 8'h00);
        #3;
        rst = 1'b1;
        #1;
        check("rst async", {gnt, uio_oe, uio_out, busy}, '0);
        model_reset();
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- randomized traffic against the model ----
        r = '0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7, 0) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(31, 0) == 0) r = '0;
            step(r, N'($urandom), $urandom, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
